// File: rtl/pipeline_sequencer_pkg.sv
// Shared types and constants for the pipeline stall/flush/freeze sequencer.
package pipeline_sequencer_pkg;

   localparam int REG_W = 5;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      RUN      = 2'd1,
      MEM_WAIT = 2'd2,
      ERROR    = 2'd3
   } state_e;

endpackage

// File: rtl/pipeline_sequencer_if.sv
// Data-memory valid/ack handshake between the sequencer and the memory side.
interface pipeline_sequencer_if;

   logic dmem_req_i;
   logic dmem_ack_i;
   logic dmem_valid_o;

   modport master (
      input  dmem_req_i,
      input  dmem_ack_i,
      output dmem_valid_o
   );

   modport slave (
      output dmem_req_i,
      output dmem_ack_i,
      input  dmem_valid_o
   );

endinterface

// File: rtl/pipeline_sequencer_hazard_detect.sv
// Load-use hazard compare: the load in EX writes a register read by the instruction in ID.
module hazard_detect
   import pipeline_sequencer_pkg::*;
(
   input  logic             memread,
   input  logic [REG_W-1:0] rd,
   input  logic [REG_W-1:0] rs1,
   input  logic [REG_W-1:0] rs2,
   output logic             hit
);

   // x0 is never a real dependency, so a load to x0 never stalls
   assign hit = memread && (rd != {REG_W{1'b0}}) && ((rd == rs1) || (rd == rs2));

endmodule

// File: rtl/pipeline_sequencer.sv
// Pipeline sequencer: FSM, memory wait/timeout counter, stall counter and
// combinational control outputs for PC, IF/ID, decoder bubble and global freeze.
module pipeline_sequencer
   import pipeline_sequencer_pkg::*;
#(
   parameter int MEM_TIMEOUT = 64,
   parameter int CNT_W       = 32
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             start_i,
   input  logic             IDEX_MemRead_i,
   input  logic [REG_W-1:0] IDEX_Rd_i,
   input  logic [REG_W-1:0] IFID_Rs1_i,
   input  logic [REG_W-1:0] IFID_Rs2_i,
   input  logic             Branch_taken_i,
   pipeline_sequencer_if.master mem,
   output logic             PCWrite_o,
   output logic             IFIDWrite_o,
   output logic             NoOp_o,
   output logic             Flush_o,
   output logic             freeze_o,
   output logic             err_o,
   output logic [CNT_W-1:0] stall_cnt_o
);

   localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1);

   state_e            state_r;
   logic [WAIT_W-1:0] wait_cnt_r;
   logic [CNT_W-1:0]  stall_cnt_r;
   logic              hit_s;

   hazard_detect u_hazard (
      .memread (IDEX_MemRead_i),
      .rd      (IDEX_Rd_i),
      .rs1     (IFID_Rs1_i),
      .rs2     (IFID_Rs2_i),
      .hit     (hit_s)
   );

   // Control outputs from current state and inputs; load-use beats a taken branch
   always_comb begin
      PCWrite_o        = 1'b0;
      IFIDWrite_o      = 1'b0;
      NoOp_o           = 1'b0;
      Flush_o          = 1'b0;
      freeze_o         = 1'b0;
      mem.dmem_valid_o = 1'b0;
      case (state_r)
         IDLE: begin
            NoOp_o   = 1'b1;
            freeze_o = 1'b1;
         end
         RUN, MEM_WAIT: begin
            mem.dmem_valid_o = (state_r == MEM_WAIT) ? 1'b1 : mem.dmem_req_i;
            if (mem.dmem_valid_o && !mem.dmem_ack_i) begin
               freeze_o = 1'b1;
            end else if (hit_s) begin
               NoOp_o = 1'b1;
            end else if (Branch_taken_i) begin
               Flush_o     = 1'b1;
               PCWrite_o   = 1'b1;
               IFIDWrite_o = 1'b1;
            end else begin
               PCWrite_o   = 1'b1;
               IFIDWrite_o = 1'b1;
            end
         end
         ERROR: begin
            NoOp_o   = 1'b1;
            freeze_o = 1'b1;
         end
         default: begin
            NoOp_o   = 1'b1;
            freeze_o = 1'b1;
         end
      endcase
   end

   // FSM, memory wait counter and saturating stall counter
   always_ff @(posedge clk_i) begin
      if (!rst_i) begin
         state_r     <= IDLE;
         wait_cnt_r  <= {WAIT_W{1'b0}};
         stall_cnt_r <= {CNT_W{1'b0}};
      end else begin
         if (((state_r == RUN) || (state_r == MEM_WAIT)) && !PCWrite_o &&
             (stall_cnt_r != {CNT_W{1'b1}})) begin
            stall_cnt_r <= stall_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
         end
         case (state_r)
            IDLE: begin
               if (start_i) begin
                  state_r <= RUN;
               end
            end
            RUN: begin
               wait_cnt_r <= {WAIT_W{1'b0}};
               if (mem.dmem_req_i && !mem.dmem_ack_i) begin
                  state_r <= MEM_WAIT;
               end
            end
            MEM_WAIT: begin
               if (mem.dmem_ack_i) begin
                  state_r    <= RUN;
                  wait_cnt_r <= {WAIT_W{1'b0}};
               end else if (wait_cnt_r == WAIT_W'(MEM_TIMEOUT - 1)) begin
                  state_r <= ERROR;
               end else begin
                  wait_cnt_r <= wait_cnt_r + {{(WAIT_W-1){1'b0}}, 1'b1};
               end
            end
            ERROR: begin
               state_r <= ERROR;
            end
            default: begin
               state_r <= IDLE;
            end
         endcase
      end
   end

   assign err_o       = (state_r == ERROR);
   assign stall_cnt_o = stall_cnt_r;

endmodule

// File: tb/tb_pipeline_sequencer.sv
// Directed self-checking bench for pipeline_sequencer (MEM_TIMEOUT=4, CNT_W=4).
module tb_pipeline_sequencer;

   logic       clk;
   logic       rst;
   logic       start;
   logic       memread;
   logic [4:0] rd;
   logic [4:0] rs1;
   logic [4:0] rs2;
   logic       branch;
   logic       pcwrite;
   logic       ifidwrite;
   logic       noop;
   logic       flush;
   logic       freeze;
   logic       err;
   logic [3:0] stall_cnt;
   int         total;
   int         bad;

   pipeline_sequencer_if mif ();

   pipeline_sequencer #(.MEM_TIMEOUT(4), .CNT_W(4)) dut (
      .clk_i          (clk),
      .rst_i          (rst),
      .start_i        (start),
      .IDEX_MemRead_i (memread),
      .IDEX_Rd_i      (rd),
      .IFID_Rs1_i     (rs1),
      .IFID_Rs2_i     (rs2),
      .Branch_taken_i (branch),
      .mem            (mif.master),
      .PCWrite_o      (pcwrite),
      .IFIDWrite_o    (ifidwrite),
      .NoOp_o         (noop),
      .Flush_o        (flush),
      .freeze_o       (freeze),
      .err_o          (err),
      .stall_cnt_o    (stall_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_inputs();
      start = 1'b0; memread = 1'b0; rd = 5'd0; rs1 = 5'd0; rs2 = 5'd0;
      branch = 1'b0; mif.dmem_req_i = 1'b0; mif.dmem_ack_i = 1'b0;
   endtask

   task automatic do_reset();
      clear_inputs();
      rst = 1'b0;
      step();
      step();
      rst = 1'b1;
   endtask

   task automatic go_run();
      do_reset();
      start = 1'b1;
      step();
      start = 1'b0;
   endtask

   task automatic test_reset();
      do_reset();
      mif.dmem_req_i = 1'b1;
      @(negedge clk);
      total++; if (noop !== 1'b1) begin bad++; $display("FAIL idle_noop got=%0b exp=1", noop); end
      total++; if (freeze !== 1'b1) begin bad++; $display("FAIL idle_freeze got=%0b exp=1", freeze); end
      total++; if (pcwrite !== 1'b0) begin bad++; $display("FAIL idle_pcwrite got=%0b exp=0", pcwrite); end
      total++; if (mif.dmem_valid_o !== 1'b0) begin bad++; $display("FAIL idle_valid got=%0b exp=0", mif.dmem_valid_o); end
      total++; if (err !== 1'b0) begin bad++; $display("FAIL reset_err got=%0b exp=0", err); end
      total++; if (stall_cnt !== 4'd0) begin bad++; $display("FAIL reset_stall got=%0d exp=0", stall_cnt); end
      mif.dmem_req_i = 1'b0;
      step();
      total++; if (freeze !== 1'b1) begin bad++; $display("FAIL idle_hold_freeze got=%0b exp=1", freeze); end
      start = 1'b1;
      step();
      start = 1'b0;
      @(negedge clk);
      total++; if (freeze !== 1'b0 || pcwrite !== 1'b1 || noop !== 1'b0) begin
         bad++; $display("FAIL start_run got=%0b%0b%0b exp=011", freeze, pcwrite, noop);
      end
      step();
   endtask

   task automatic test_load_use();
      go_run();
      memread = 1'b1; rd = 5'd5; rs1 = 5'd5; rs2 = 5'd1;
      @(negedge clk);
      total++; if (pcwrite !== 1'b0 || ifidwrite !== 1'b0 || noop !== 1'b1) begin
         bad++; $display("FAIL lu_stall pc/ifid/noop got=%0b%0b%0b exp=001", pcwrite, ifidwrite, noop);
      end
      step();
      memread = 1'b0;
      @(negedge clk);
      total++; if (pcwrite !== 1'b1 || noop !== 1'b0) begin
         bad++; $display("FAIL lu_resume pc/noop got=%0b%0b exp=10", pcwrite, noop);
      end
      total++; if (stall_cnt !== 4'd1) begin bad++; $display("FAIL lu_stall_cnt got=%0d exp=1", stall_cnt); end
      step();
      memread = 1'b1; rd = 5'd7; rs1 = 5'd2; rs2 = 5'd7;
      @(negedge clk);
      total++; if (noop !== 1'b1 || pcwrite !== 1'b0) begin
         bad++; $display("FAIL lu_rs2 noop/pc got=%0b%0b exp=10", noop, pcwrite);
      end
      go_run();
      memread = 1'b1; rd = 5'd0; rs1 = 5'd0; rs2 = 5'd0;
      @(negedge clk);
      total++; if (pcwrite !== 1'b1 || noop !== 1'b0) begin
         bad++; $display("FAIL lu_x0 pc/noop got=%0b%0b exp=10", pcwrite, noop);
      end
      step();
      memread = 1'b0;
      @(negedge clk);
      total++; if (stall_cnt !== 4'd0) begin bad++; $display("FAIL lu_x0_cnt got=%0d exp=0", stall_cnt); end
      step();
   endtask

   task automatic test_branch_hazard();
      go_run();
      memread = 1'b1; rd = 5'd3; rs1 = 5'd3; rs2 = 5'd9; branch = 1'b1;
      @(negedge clk);
      total++; if (flush !== 1'b0 || noop !== 1'b1) begin
         bad++; $display("FAIL br_lu flush/noop got=%0b%0b exp=01", flush, noop);
      end
      step();
      memread = 1'b0;
      @(negedge clk);
      total++; if (flush !== 1'b1 || pcwrite !== 1'b1 || ifidwrite !== 1'b1 || noop !== 1'b0) begin
         bad++; $display("FAIL br_flush f/pc/ifid/noop got=%0b%0b%0b%0b exp=1110", flush, pcwrite, ifidwrite, noop);
      end
      step();
      branch = 1'b0;
      @(negedge clk);
      total++; if (flush !== 1'b0 || stall_cnt !== 4'd1) begin
         bad++; $display("FAIL br_after flush=%0b cnt=%0d exp flush=0 cnt=1", flush, stall_cnt);
      end
      step();
   endtask

   task automatic test_mem_zero_wait();
      go_run();
      mif.dmem_req_i = 1'b1; mif.dmem_ack_i = 1'b1;
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         total++; if (freeze !== 1'b0 || mif.dmem_valid_o !== 1'b1 || pcwrite !== 1'b1) begin
            bad++; $display("FAIL mem0 cyc%0d freeze/valid/pc got=%0b%0b%0b exp=011", i, freeze, mif.dmem_valid_o, pcwrite);
         end
         step();
      end
      clear_inputs();
      @(negedge clk);
      total++; if (freeze !== 1'b0 || stall_cnt !== 4'd0) begin
         bad++; $display("FAIL mem0_after freeze=%0b cnt=%0d exp 0/0", freeze, stall_cnt);
      end
      step();
   endtask

   task automatic test_mem_wait3();
      go_run();
      mif.dmem_req_i = 1'b1; mif.dmem_ack_i = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         total++; if (freeze !== 1'b1 || mif.dmem_valid_o !== 1'b1 || pcwrite !== 1'b0 || noop !== 1'b0) begin
            bad++; $display("FAIL mem3 cyc%0d freeze/valid/pc/noop got=%0b%0b%0b%0b exp=1100", i, freeze, mif.dmem_valid_o, pcwrite, noop);
         end
         step();
      end
      mif.dmem_ack_i = 1'b1;
      @(negedge clk);
      total++; if (freeze !== 1'b0 || mif.dmem_valid_o !== 1'b1 || pcwrite !== 1'b1) begin
         bad++; $display("FAIL mem3_ack freeze/valid/pc got=%0b%0b%0b exp=011", freeze, mif.dmem_valid_o, pcwrite);
      end
      step();
      clear_inputs();
      @(negedge clk);
      total++; if (freeze !== 1'b0 || mif.dmem_valid_o !== 1'b0 || stall_cnt !== 4'd3) begin
         bad++; $display("FAIL mem3_after freeze=%0b valid=%0b cnt=%0d exp 0/0/3", freeze, mif.dmem_valid_o, stall_cnt);
      end
      step();
   endtask

   task automatic test_timeout();
      go_run();
      mif.dmem_req_i = 1'b1; mif.dmem_ack_i = 1'b0;
      step();
      mif.dmem_req_i = 1'b0;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         total++; if (err !== 1'b0 || freeze !== 1'b1 || mif.dmem_valid_o !== 1'b1) begin
            bad++; $display("FAIL to_wait cyc%0d err/freeze/valid got=%0b%0b%0b exp=011", i, err, freeze, mif.dmem_valid_o);
         end
         step();
      end
      @(negedge clk);
      total++; if (err !== 1'b1 || freeze !== 1'b1 || mif.dmem_valid_o !== 1'b0 || noop !== 1'b1 || pcwrite !== 1'b0) begin
         bad++; $display("FAIL to_err err/freeze/valid/noop/pc got=%0b%0b%0b%0b%0b exp=11010", err, freeze, mif.dmem_valid_o, noop, pcwrite);
      end
      total++; if (stall_cnt !== 4'd5) begin bad++; $display("FAIL to_cnt got=%0d exp=5", stall_cnt); end
      start = 1'b1; mif.dmem_ack_i = 1'b1;
      step();
      start = 1'b0; mif.dmem_ack_i = 1'b0;
      step();
      @(negedge clk);
      total++; if (err !== 1'b1 || freeze !== 1'b1 || stall_cnt !== 4'd5) begin
         bad++; $display("FAIL to_sticky err=%0b freeze=%0b cnt=%0d exp 1/1/5", err, freeze, stall_cnt);
      end
      step();
   endtask

   task automatic test_reset_mid_wait();
      go_run();
      mif.dmem_req_i = 1'b1; mif.dmem_ack_i = 1'b0;
      step();
      step();
      rst = 1'b0;
      step();
      rst = 1'b1; mif.dmem_req_i = 1'b0;
      @(negedge clk);
      total++; if (mif.dmem_valid_o !== 1'b0 || freeze !== 1'b1 || noop !== 1'b1 || stall_cnt !== 4'd0 || err !== 1'b0) begin
         bad++; $display("FAIL rst_wait valid=%0b freeze=%0b noop=%0b cnt=%0d err=%0b exp 0/1/1/0/0",
                         mif.dmem_valid_o, freeze, noop, stall_cnt, err);
      end
      step();
   endtask

   task automatic test_saturation();
      go_run();
      memread = 1'b1; rd = 5'd4; rs1 = 5'd4;
      for (int i = 0; i < 20; i++) step();
      @(negedge clk);
      total++; if (stall_cnt !== 4'd15) begin bad++; $display("FAIL sat_cnt got=%0d exp=15", stall_cnt); end
      step();
      @(negedge clk);
      total++; if (stall_cnt !== 4'd15) begin bad++; $display("FAIL sat_hold got=%0d exp=15", stall_cnt); end
      clear_inputs();
      step();
   endtask

   initial begin
      total = 0;
      bad   = 0;
      rst   = 1'b0;
      clear_inputs();
      test_reset();
      test_load_use();
      test_branch_hazard();
      test_mem_zero_wait();
      test_mem_wait3();
      test_timeout();
      test_reset_mid_wait();
      test_saturation();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
